// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo block.
//   DEFAULT_DATA_WIDTH    : default word width in bits
//   DEFAULT_ADDRESS_WIDTH : default log2 of FIFO depth
//   fifo_depth()          : number of words for a given address width
package sync_fifo_pkg;

   localparam int DEFAULT_DATA_WIDTH    = 8;
   localparam int DEFAULT_ADDRESS_WIDTH = 4;

   function automatic int fifo_depth(input int address_width);
      return 1 << address_width;
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM used as FIFO storage when USE_RAM=1.
// Synchronous write, registered read; contents are never cleared.
//   clk        : clock
//   rst        : async active-low reset, clears only the read register
//   write_en   : write strobe
//   write_addr : write address
//   write_data : write data
//   read_en    : load read register from mem[read_addr]
//   read_addr  : read address
//   read_data  : registered read data
module sync_fifo_ram
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     write_en,
   input  logic [ADDRESS_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0]    write_data,
   input  logic                     read_en,
   input  logic [ADDRESS_WIDTH-1:0] read_addr,
   output logic [DATA_WIDTH-1:0]    read_data
);

   localparam int DEPTH = fifo_depth(ADDRESS_WIDTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // No reset on the array so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (write_en) begin
         mem[write_addr] <= write_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         read_data <= '0;
      end else if (read_en) begin
         read_data <= mem[read_addr];
      end
   end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock synchronous FIFO, 2^ADDRESS_WIDTH words of DATA_WIDTH bits.
// USE_RAM=0: register array, first-word-fall-through data_out.
// USE_RAM=1: sync_fifo_ram storage, data_out loaded on each accepted pop.
// Optional macro SYNC_FIFO_ASSERT_EN enables simulation-only overflow,
// underflow and occupancy-range checks.
//   clk           : clock, rising edge
//   rst           : async active-low reset
//   data_in       : write data
//   write_en      : push request (ignored while full)
//   read_en       : pop request (ignored while empty)
//   data_out      : read data
//   empty         : occupancy == 0
//   full          : occupancy == depth
//   fifo_ocupancy : words stored, 0..depth
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
   parameter int USE_RAM       = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    data_in,
   input  logic                     write_en,
   input  logic                     read_en,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic                     empty,
   output logic                     full,
   output logic [ADDRESS_WIDTH:0]   fifo_ocupancy
);

   localparam int DEPTH = fifo_depth(ADDRESS_WIDTH);
   localparam logic [ADDRESS_WIDTH:0] DEPTH_COUNT = (ADDRESS_WIDTH+1)'(DEPTH);

   logic [ADDRESS_WIDTH-1:0] wr_ptr;
   logic [ADDRESS_WIDTH-1:0] rd_ptr;
   logic                     push;
   logic                     pop;

   // Flags come from the registered count, so a push while full is dropped
   // even when a pop frees a slot on the same edge.
   assign empty = (fifo_ocupancy == '0);
   assign full  = (fifo_ocupancy == DEPTH_COUNT);
   assign push  = write_en && !full;
   assign pop   = read_en && !empty;

   // Pointers wrap naturally at 2^ADDRESS_WIDTH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_ocupancy <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_ocupancy <= fifo_ocupancy + 1'b1;
            2'b01:   fifo_ocupancy <= fifo_ocupancy - 1'b1;
            default: fifo_ocupancy <= fifo_ocupancy;
         endcase
      end
   end

   generate
      if (USE_RAM != 0) begin : g_ram
         sync_fifo_ram #(
            .DATA_WIDTH    (DATA_WIDTH),
            .ADDRESS_WIDTH (ADDRESS_WIDTH)
         ) u_ram (
            .clk        (clk),
            .rst        (rst),
            .write_en   (push),
            .write_addr (wr_ptr),
            .write_data (data_in),
            .read_en    (pop),
            .read_addr  (rd_ptr),
            .read_data  (data_out)
         );
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] mem [DEPTH];

         always_ff @(posedge clk) begin
            if (push) begin
               mem[wr_ptr] <= data_in;
            end
         end

         // Head word is always presented; meaningless while empty.
         assign data_out = mem[rd_ptr];
      end
   endgenerate

`ifdef SYNC_FIFO_ASSERT_EN
   always @(posedge clk) begin
      if (rst) begin
         if (write_en && full) begin
            $display("sync_fifo warning: overflow, push while full at %0t", $time);
         end
         if (read_en && empty) begin
            $display("sync_fifo warning: underflow, pop while empty at %0t", $time);
         end
         if (fifo_ocupancy > DEPTH_COUNT) begin
            $error("sync_fifo: occupancy %0d exceeds depth at %0t", fifo_ocupancy, $time);
         end
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: one register-array instance and one
// RAM-backed instance share stimulus; a queue scoreboard supplies expected data.
module tb_sync_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] data_in = 8'd0;
   logic       write_en = 1'b0;
   logic       read_en = 1'b0;

   logic [7:0] dout_r, dout_m;
   logic       empty_r, empty_m, full_r, full_m;
   logic [4:0] occ_r, occ_m;

   int total = 0;
   int bad = 0;

   logic [7:0] exp_q[$];
   logic [7:0] ram_exp = 8'd0;

   always #5 clk = ~clk;

   sync_fifo #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .USE_RAM(0)) u_reg (
      .clk(clk), .rst(rst), .data_in(data_in), .write_en(write_en), .read_en(read_en),
      .data_out(dout_r), .empty(empty_r), .full(full_r), .fifo_ocupancy(occ_r)
   );

   sync_fifo #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .USE_RAM(1)) u_ram (
      .clk(clk), .rst(rst), .data_in(data_in), .write_en(write_en), .read_en(read_en),
      .data_out(dout_m), .empty(empty_m), .full(full_m), .fifo_ocupancy(occ_m)
   );

   // One clock of stimulus; scoreboard updated with the model's view of the edge.
   task automatic cycle(input logic we, input logic re, input logic [7:0] din);
      logic push_ok, pop_ok;
      write_en = we;
      read_en  = re;
      data_in  = din;
      @(posedge clk);
      push_ok = we && (exp_q.size() < 16);
      pop_ok  = re && (exp_q.size() > 0);
      if (pop_ok) ram_exp = exp_q.pop_front();
      if (push_ok) exp_q.push_back(din);
      #1;
      write_en = 1'b0;
      read_en  = 1'b0;
   endtask

   task automatic assert_rst();
      rst = 1'b0;
      exp_q.delete();
      ram_exp = 8'd0;
      #1;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if (occ_r !== 5'd0 || occ_m !== 5'd0 || empty_r !== 1'b1 || empty_m !== 1'b1 ||
          full_r !== 1'b0 || full_m !== 1'b0 || dout_m !== 8'd0) begin
         bad++;
         $display("FAIL reset_init: occ=%0d/%0d empty=%b/%b full=%b/%b dout_m=%0d, want occ=0 empty=1 full=0 dout_m=0",
                  occ_r, occ_m, empty_r, empty_m, full_r, full_m, dout_m);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(7 + i));
      total++;
      if (occ_r !== 5'd3 || occ_m !== 5'd3) begin
         bad++;
         $display("FAIL reset_pre_occ: occ=%0d/%0d want 3", occ_r, occ_m);
      end
      #3;
      assert_rst();
      total++;
      if (occ_r !== 5'd0 || occ_m !== 5'd0 || empty_r !== 1'b1 || empty_m !== 1'b1 ||
          full_r !== 1'b0 || full_m !== 1'b0 || dout_m !== 8'd0) begin
         bad++;
         $display("FAIL reset_pulse: occ=%0d/%0d empty=%b/%b full=%b/%b dout_m=%0d, want 0/1/0/0",
                  occ_r, occ_m, empty_r, empty_m, full_r, full_m, dout_m);
      end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         cycle(1'b1, 1'b0, 8'(32 + i));
         total++;
         if (occ_r !== 5'(exp_q.size()) || occ_m !== 5'(exp_q.size()) || dout_r !== exp_q[0]) begin
            bad++;
            $display("FAIL fill_step%0d: occ=%0d/%0d dout_r=%0d want occ=%0d dout_r=%0d",
                     i, occ_r, occ_m, dout_r, exp_q.size(), exp_q[0]);
         end
      end
      total++;
      if (full_r !== 1'b1 || full_m !== 1'b1 || occ_r !== 5'd16 || occ_m !== 5'd16 ||
          empty_r !== 1'b0 || empty_m !== 1'b0) begin
         bad++;
         $display("FAIL fill_full: full=%b/%b occ=%0d/%0d empty=%b/%b want full=1 occ=16 empty=0",
                  full_r, full_m, occ_r, occ_m, empty_r, empty_m);
      end
      cycle(1'b1, 1'b0, 8'd99);
      total++;
      if (full_r !== 1'b1 || full_m !== 1'b1 || occ_r !== 5'd16 || occ_m !== 5'd16 || dout_r !== 8'd32) begin
         bad++;
         $display("FAIL fill_overflow: full=%b/%b occ=%0d/%0d dout_r=%0d want full=1 occ=16 dout_r=32",
                  full_r, full_m, occ_r, occ_m, dout_r);
      end
   endtask

   task automatic test_drain();
      total++;
      if (dout_r !== 8'd32) begin
         bad++;
         $display("FAIL drain_fwft_head: dout_r=%0d want 32", dout_r);
      end
      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, 1'b1, 8'd0);
         total++;
         if (dout_m !== ram_exp || ram_exp !== 8'(32 + i) || occ_r !== 5'(exp_q.size()) ||
             occ_m !== 5'(exp_q.size()) || (exp_q.size() > 0 && dout_r !== exp_q[0])) begin
            bad++;
            $display("FAIL drain_step%0d: dout_m=%0d dout_r=%0d occ=%0d/%0d want dout_m=%0d occ=%0d",
                     i, dout_m, dout_r, occ_r, occ_m, 32 + i, exp_q.size());
         end
      end
      total++;
      if (empty_r !== 1'b1 || empty_m !== 1'b1 || occ_r !== 5'd0 || occ_m !== 5'd0 || full_r !== 1'b0) begin
         bad++;
         $display("FAIL drain_empty: empty=%b/%b occ=%0d/%0d full_r=%b want empty=1 occ=0 full=0",
                  empty_r, empty_m, occ_r, occ_m, full_r);
      end
      cycle(1'b0, 1'b1, 8'd0);
      total++;
      if (dout_m !== 8'd47 || occ_r !== 5'd0 || occ_m !== 5'd0 || empty_m !== 1'b1) begin
         bad++;
         $display("FAIL drain_underflow: dout_m=%0d occ=%0d/%0d empty_m=%b want dout_m=47 occ=0 empty=1",
                  dout_m, occ_r, occ_m, empty_m);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(100 + i));
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b1, 8'd0);
         total++;
         if (dout_m !== ram_exp || ram_exp !== 8'(100 + i) || occ_m !== 5'(exp_q.size()) ||
             occ_r !== 5'(exp_q.size())) begin
            bad++;
            $display("FAIL wrap_pop%0d: dout_m=%0d occ=%0d/%0d want dout_m=%0d occ=%0d",
                     i, dout_m, occ_r, occ_m, 100 + i, exp_q.size());
         end
      end
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 1'b1, 8'(i));
         total++;
         if (occ_r !== 5'd1 || occ_m !== 5'd1 || exp_q.size() != 1 || dout_r !== 8'(i) ||
             dout_m !== ram_exp) begin
            bad++;
            $display("FAIL wrap_concurrent%0d: occ=%0d/%0d dout_r=%0d dout_m=%0d want occ=1 dout_r=%0d dout_m=%0d",
                     i, occ_r, occ_m, dout_r, dout_m, i, ram_exp);
         end
      end
      cycle(1'b0, 1'b1, 8'd0);
      total++;
      if (dout_m !== 8'd11 || empty_r !== 1'b1 || empty_m !== 1'b1 || occ_r !== 5'd0) begin
         bad++;
         $display("FAIL wrap_last: dout_m=%0d empty=%b/%b occ_r=%0d want dout_m=11 empty=1 occ=0",
                  dout_m, empty_r, empty_m, occ_r);
      end
      cycle(1'b0, 1'b1, 8'd0);
      total++;
      if (dout_m !== ram_exp || dout_m !== 8'd11 || occ_r !== 5'd0 || occ_m !== 5'd0) begin
         bad++;
         $display("FAIL wrap_pop_empty: dout_m=%0d occ=%0d/%0d want dout_m=11 occ=0",
                  dout_m, occ_r, occ_m);
      end
   endtask

   task automatic test_reset_full();
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(200 + i));
      total++;
      if (full_r !== 1'b1 || full_m !== 1'b1) begin
         bad++;
         $display("FAIL rstfull_pre: full=%b/%b want 1", full_r, full_m);
      end
      #3;
      assert_rst();
      total++;
      if (occ_r !== 5'd0 || occ_m !== 5'd0 || empty_r !== 1'b1 || empty_m !== 1'b1 ||
          full_r !== 1'b0 || full_m !== 1'b0 || dout_m !== 8'd0) begin
         bad++;
         $display("FAIL rstfull_clear: occ=%0d/%0d empty=%b/%b full=%b/%b dout_m=%0d want 0/1/0/0",
                  occ_r, occ_m, empty_r, empty_m, full_r, full_m, dout_m);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      cycle(1'b1, 1'b0, 8'd5);
      total++;
      if (dout_r !== 8'd5 || occ_r !== 5'd1 || occ_m !== 5'd1 || empty_m !== 1'b0) begin
         bad++;
         $display("FAIL rstfull_push: dout_r=%0d occ=%0d/%0d empty_m=%b want dout_r=5 occ=1 empty=0",
                  dout_r, occ_r, occ_m, empty_m);
      end
      cycle(1'b0, 1'b1, 8'd0);
      total++;
      if (dout_m !== 8'd5 || dout_m !== ram_exp || empty_r !== 1'b1 || empty_m !== 1'b1) begin
         bad++;
         $display("FAIL rstfull_pop: dout_m=%0d empty=%b/%b want dout_m=5 empty=1",
                  dout_m, empty_r, empty_m);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_reset_full();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock synchronous FIFO of 2^ADDRESS_WIDTH words of DATA_WIDTH bits. It has full/empty flags and an occupancy count. It is a general-purpose buffer between a producer and a consumer in the same clock domain. Storage is either a register array with first-word-fall-through reads, or an inferred RAM with a one-cycle registered read.

## Interface
- DATA_WIDTH, 8, word width in bits.
- ADDRESS_WIDTH, 4, log2 of depth; depth = 2^ADDRESS_WIDTH (16 by default).
- USE_RAM, 0, 0 = register array with first-word-fall-through read; 1 = RAM storage with registered read.

- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  DATA_WIDTH  write data.
- write_en  in  1  push request.
- read_en  in  1  pop request.
- data_out  out  DATA_WIDTH  read data.
- empty  out  1  occupancy == 0.
- full  out  1  occupancy == depth.
- fifo_ocupancy  out  ADDRESS_WIDTH+1  words currently stored, range 0..depth.

## Operation
- Reset (rst low, asynchronous):
  - write and read pointers = 0, fifo_ocupancy = 0, empty = 1, full = 0.
  - data_out register = 0 (USE_RAM=1).
  - Storage contents are not cleared.
  - Reset asserted mid-operation discards all queued data immediately.
- Push accepted when write_en=1 and full=0: mem[wr_ptr] <= data_in, wr_ptr increments.
- Push with full=1 is ignored, even if a pop happens in the same cycle.
- Pop accepted when read_en=1 and empty=0: rd_ptr increments.
- Pop with empty=1 is ignored and data_out holds its value.
- Pointers are ADDRESS_WIDTH bits and wrap modulo depth with no special-casing.
- Occupancy update per edge: +1 on push-only, -1 on pop-only, unchanged on both or neither.
- empty and full are decoded from the registered occupancy.
- Simultaneous push and pop when 0 < occupancy < depth: both take effect and occupancy is unchanged.
- Simultaneous push and pop when empty: only the push takes effect.
- USE_RAM=0: data_out = mem[rd_ptr] combinationally. The head word is visible whenever empty=0. A pop advances to the next word after the edge.
- USE_RAM=1: data_out is a register loaded with mem[rd_ptr] on the edge of an accepted pop. The popped word appears after that edge.
- data_out is don't-care while empty=1 in USE_RAM=0 mode.

## Timing
- Write-to-flags latency: 1 edge. After the accepted push edge, empty=0 and fifo_ocupancy=1.
- USE_RAM=0 read latency: 0. A word written at edge N is on data_out after edge N if it is the head.
- USE_RAM=1 read latency: 1. read_en at edge N puts the head word on data_out after edge N.
- Continuous read_en=1 streams one word per cycle in both modes.
- full is asserted after the 16th consecutive push (default parameters).
- empty is asserted after the last pop edge.
- Write-through (same-cycle read of a word being written) is not supported; the word is readable from the next cycle.

## Configuration
- SYNC_FIFO_ASSERT_EN
  - Defined: simulation-only checks print a warning with $time on a push attempted while full (overflow) and on a pop attempted while empty (underflow). They also report an error if fifo_ocupancy ever exceeds depth.
  - Undefined: no checking logic, and synthesized behaviour is identical.

## Structure
- Package sync_fifo_pkg:
  - default constants DATA_WIDTH=8 and ADDRESS_WIDTH=4;
  - helper function computing depth from ADDRESS_WIDTH.
- Sub-module sync_fifo_ram:
  - simple dual-port RAM, 2^ADDRESS_WIDTH x DATA_WIDTH;
  - synchronous write and registered read;
  - instantiated only when USE_RAM=1.
- Pointer, occupancy and flag logic lives in the top module and is shared by both modes.

## Test plan
- Reset: pulse rst low mid-idle -> empty=1, full=0, fifo_ocupancy=0.
- Fill: 16 consecutive pushes of 32..47 -> full=1, fifo_ocupancy=16. A 17th push (value 99) is ignored and occupancy stays 16.
- Drain, USE_RAM=0: hold read_en=1 -> data_out=32 before the first edge, then 33..47 on successive cycles. Then empty=1 and fifo_ocupancy=0.
- Drain, USE_RAM=1: hold read_en=1 -> data_out=32 after the first edge, then 33..47 on successive cycles. Then empty=1.
- Wrap and concurrency:
  - Push 10 words, pop 10, push 12 words 0..11 while popping concurrently.
  - Required: order preserved across pointer wrap and occupancy correct each cycle.
  - Pop while empty leaves data_out and occupancy unchanged.
- Reset while full: fill 16 words, assert rst -> immediately fifo_ocupancy=0 and empty=1. A subsequent push/pop of 5 returns 5.
